// File: rtl/mtl2_timer_pkg.sv
// mtl2_timer_pkg: shared definitions for the MTL2 multi-channel interval timer.
// Holds the per-channel register offsets, CONTROL/STATUS bit indices, the packed
// CONTROL layout and the address-width helper used by the top level.
package mtl2_timer_pkg;

  // Per-channel register offsets (address[1:0]).
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // CONTROL bit indices.
  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;
  localparam int unsigned CTL_PSEL  = 4;
  localparam int unsigned CTL_W     = 5;

  // STATUS bit indices.
  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;
  localparam int unsigned ST_W   = 2;

  // Packed CONTROL register; field order matches the CTL_* indices above.
  typedef struct packed {
    logic psel;
    logic stop;
    logic start;
    logic cont;
    logic ito;
  } ctl_t;

  // Channel field width plus two register bits, never narrower than 3.
  function automatic int unsigned addr_width(input int unsigned num_ch);
    int unsigned w;
    w = $clog2(num_ch) + 2;
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mtl2_timer_channel.sv
// mtl2_timer_channel: one interval-timer channel.
// Holds the down-counter, PERIOD/CONTROL/TO/RUN/SNAPSHOT registers, the zero
// edge detector and the channel interrupt.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   presc_tick    : one-cycle pulse from the shared prescaler
//   wr_status     : write strobe to STATUS (clears TO)
//   wr_control    : write strobe to CONTROL, data on wctl
//   wr_period     : write strobe to PERIOD, data on wdata
//   wr_snap       : write strobe to SNAPSHOT (captures the live counter)
//   ctl, to, run  : register state for readback
//   period, snap  : PERIOD and SNAPSHOT for readback
//   irq           : TO & ITO
module mtl2_timer_channel
  import mtl2_timer_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 19999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             presc_tick,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [CNT_W-1:0] wdata,
  input  ctl_t             wctl,
  output ctl_t             ctl,
  output logic             to,
  output logic             run,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             irq
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  ctl_t             ctl_q;
  logic             to_q, to_d;
  logic             run_q, run_d;
  logic             zero_q;
  logic             force_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] snap_q;

  logic tick;
  logic cnt_zero;
  logic to_evt;

  always_comb begin
    tick     = ctl_q.psel ? presc_tick : 1'b1;
    cnt_zero = (cnt_q == '0);
    // Edge detect: a counter parked at zero raises only one event.
    to_evt   = cnt_zero & ~zero_q;

    // Set beats clear so a timeout coinciding with a STATUS write is kept.
    to_d = to_q;
    if (to_evt) begin
      to_d = 1'b1;
    end else if (wr_status) begin
      to_d = 1'b0;
    end

    // START wins over STOP; a PERIOD write always halts the channel.
    run_d = run_q;
    if (wr_period) begin
      run_d = 1'b0;
    end else if (wr_control && wctl.start) begin
      run_d = 1'b1;
    end else if (wr_control && wctl.stop) begin
      run_d = 1'b0;
    end else if (run_q && tick && cnt_zero && !ctl_q.cont) begin
      run_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (force_q) begin
      cnt_d = period_q;
    end else if (run_q && tick) begin
      cnt_d = cnt_zero ? period_q : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctl_q    <= '0;
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      // Avoid a spurious event straight out of reset if the default is zero.
      zero_q   <= (RST_PERIOD == '0);
      force_q  <= 1'b0;
      cnt_q    <= RST_PERIOD;
      period_q <= RST_PERIOD;
      snap_q   <= '0;
    end else begin
      to_q    <= to_d;
      run_q   <= run_d;
      zero_q  <= cnt_zero;
      force_q <= wr_period;
      cnt_q   <= cnt_d;
      if (wr_control) ctl_q    <= wctl;
      if (wr_period)  period_q <= wdata;
      if (wr_snap)    snap_q   <= cnt_q;
    end
  end

  assign ctl    = ctl_q;
  assign to     = to_q;
  assign run    = run_q;
  assign period = period_q;
  assign snap   = snap_q;
  assign irq    = to_q & ctl_q.ito;

endmodule

// File: rtl/mtl2_multi_timer.sv
// mtl2_multi_timer: NUM_CH independent interval timers behind one Avalon-MM slave.
// Holds the shared prescaler, address decode, registered read mux and irq OR.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   address      : [ADDR_W-1:2] channel, [1:0] register
//   chipselect   : slave select
//   write_n      : active-low write
//   writedata    : write data
//   readdata     : read data, one cycle after address
//   irq_vec      : per-channel interrupts
//   irq          : OR of irq_vec
module mtl2_multi_timer
  import mtl2_timer_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEFAULT_PERIOD = 19999,
  parameter int unsigned PRESCALE       = 50,
  parameter int unsigned ADDR_W         = addr_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam int unsigned CH_W = ADDR_W - 2;
  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic            wr_en;

  assign ch_sel  = address[ADDR_W-1:2];
  assign reg_sel = address[1:0];
  assign wr_en   = chipselect & ~write_n;

  // Bits of writedata above CNT_W are dropped on purpose.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Free-running prescaler; channel activity never resets it.
  logic [PW-1:0] presc_q;
  logic          presc_tick;

  assign presc_tick = (presc_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (presc_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  ctl_t             ctl_arr    [NUM_CH];
  logic [CNT_W-1:0] period_arr [NUM_CH];
  logic [CNT_W-1:0] snap_arr   [NUM_CH];
  logic [NUM_CH-1:0] to_vec;
  logic [NUM_CH-1:0] run_vec;

  // Out-of-range channel numbers match no instance, so their writes vanish.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_hit;
    assign ch_hit = wr_en && (ch_sel == CH_W'(i));

    mtl2_timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .presc_tick (presc_tick),
      .wr_status  (ch_hit && (reg_sel == REG_STATUS)),
      .wr_control (ch_hit && (reg_sel == REG_CONTROL)),
      .wr_period  (ch_hit && (reg_sel == REG_PERIOD)),
      .wr_snap    (ch_hit && (reg_sel == REG_SNAP)),
      .wdata      (writedata[CNT_W-1:0]),
      .wctl       (ctl_t'(writedata[CTL_W-1:0])),
      .ctl        (ctl_arr[i]),
      .to         (to_vec[i]),
      .run        (run_vec[i]),
      .period     (period_arr[i]),
      .snap       (snap_arr[i]),
      .irq        (irq_vec[i])
    );
  end

  // Read mux is address-only; readdata refreshes every cycle.
  logic [DATA_W-1:0] rd_mux;
  logic [ST_W-1:0]   st_bits;

  always_comb begin
    rd_mux  = '0;
    st_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        st_bits[ST_TO]  = to_vec[i];
        st_bits[ST_RUN] = run_vec[i];
        unique case (reg_sel)
          REG_STATUS:  rd_mux = DATA_W'(st_bits);
          REG_CONTROL: rd_mux = DATA_W'(ctl_arr[i]);
          REG_PERIOD:  rd_mux = DATA_W'(period_arr[i]);
          REG_SNAP:    rd_mux = DATA_W'(snap_arr[i]);
        endcase
      end
    end
  end

  logic [DATA_W-1:0] readdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_mtl2_multi_timer.sv
// tb_mtl2_multi_timer: scoreboard bench for mtl2_multi_timer (NUM_CH=3, CNT_W=16).
// Stimulus tasks push expected readdata / {irq, irq_vec} ranges into a queue;
// a monitor pops and compares one cycle after each issued check.
module tb_mtl2_multi_timer;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PRESCALE = 50;
  localparam int unsigned ADDR_W   = 4;

  localparam logic [1:0] ST = 2'd0;
  localparam logic [1:0] CT = 2'd1;
  localparam logic [1:0] PE = 2'd2;
  localparam logic [1:0] SN = 2'd3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  always #5 clk = ~clk;

  mtl2_multi_timer #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DATA_W         (DATA_W),
    .DEFAULT_PERIOD (19999),
    .PRESCALE       (PRESCALE),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  typedef struct {
    bit          is_irq;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } exp_t;

  exp_t sb[$];
  bit   chk_issue = 1'b0;
  bit   chk_valid = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_wait;
  bit   seen;

  task automatic compare(input string name, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
    total++;
    if ($isunknown(act) || act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h..0x%0h", name, act, lo, hi);
    end
  endtask

  // Monitor: output is valid one edge after a check is issued.
  always @(posedge clk) chk_valid <= chk_issue;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: output with no expectation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        compare(e.name, e.is_irq ? 32'({irq, irq_vec}) : readdata, e.lo, e.hi);
      end
    end
  end

  task automatic bus(input int ch, input logic [1:0] rg, input bit wr, input logic [31:0] d);
    address    = ADDR_W'((ch << 2) | int'(rg));
    chipselect = 1'b1;
    write_n    = ~wr;
    writedata  = d;
  endtask

  task automatic wr(input int ch, input logic [1:0] rg, input logic [31:0] d);
    bus(ch, rg, 1'b1, d);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push(input bit is_irq, input logic [31:0] lo, input logic [31:0] hi,
                      input string name);
    exp_t e;
    e.is_irq = is_irq;
    e.lo     = lo;
    e.hi     = hi;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic rd(input int ch, input logic [1:0] rg, input logic [31:0] lo,
                    input logic [31:0] hi, input string name);
    bus(ch, rg, 1'b0, 32'h0);
    push(1'b0, lo, hi, name);
    chk_issue = 1'b1;
    @(negedge clk);
    chk_issue  = 1'b0;
    chipselect = 1'b0;
  endtask

  // Checks {irq, irq_vec} after the next edge.
  task automatic chk_irq(input logic [31:0] exp, input string name);
    push(1'b1, exp, exp, name);
    chk_issue = 1'b1;
    @(negedge clk);
    chk_issue = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset defaults.
    rd(0, PE, 19999, 19999, "rst_period");
    rd(0, ST, 0, 0, "rst_status");
    rd(0, CT, 0, 0, "rst_control");
    rd(0, SN, 0, 0, "rst_snap");
    chk_irq(0, "rst_irq");

    // Continuous ch1, PERIOD=9: load at +1, zero 9 edges later, TO the edge after.
    wr(1, PE, 9);
    wr(1, CT, 32'h7);
    idle(8);
    chk_irq(0, "cont_before_to");
    chk_irq(32'hA, "cont_first_to");
    wr(1, ST, 0);
    chk_irq(0, "cont_cleared");
    idle(6);
    chk_irq(0, "cont_before_2nd");
    chk_irq(32'hA, "cont_second_to");

    // STATUS clear landing on the timeout edge: set wins.
    wr(1, ST, 0);
    idle(8);
    wr(1, ST, 0);
    chk_irq(32'hA, "clear_vs_event");
    rd(1, ST, 3, 3, "status_run_to");
    wr(1, CT, 32'h8);
    rd(1, ST, 1, 1, "stopped");
    wr(1, CT, 32'hC);
    rd(1, ST, 3, 3, "start_wins");
    rd(1, CT, 32'hC, 32'hC, "ctl_strobe_readback");
    wr(1, CT, 32'h8);
    wr(1, ST, 0);
    rd(1, ST, 0, 0, "ch1_idle");

    // One-shot ch2 on prescaler: TO after third tick, first tick 1..50 edges out.
    wr(2, PE, 3);
    wr(2, CT, 32'h15);
    seen = 1'b0;
    n_wait = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (irq) begin
        seen = 1'b1;
        n_wait = i;
        break;
      end
    end
    compare("oneshot_to_latency", seen ? n_wait : 0, 102, 151);
    idle(60);
    rd(2, ST, 1, 1, "oneshot_done");
    wr(2, ST, 0);
    idle(250);
    chk_irq(0, "oneshot_single_to");
    wr(2, SN, 0);
    rd(2, SN, 3, 3, "oneshot_holds_period");

    // PERIOD=0 continuous: counter pinned at zero, exactly one event.
    wr(2, PE, 0);
    wr(2, CT, 32'h7);
    chk_irq(32'hC, "wrap_first_to");
    wr(2, ST, 0);
    chk_irq(0, "wrap_cleared");
    idle(20);
    chk_irq(0, "wrap_no_repeat");
    rd(2, ST, 2, 2, "wrap_running");
    wr(2, CT, 32'h8);
    wr(2, PE, 32'hABCD_0007);
    rd(2, PE, 7, 7, "period_truncated");

    // Snapshot on ch0: 1000 loaded, 100 decrements before capture.
    wr(0, PE, 1000);
    wr(0, CT, 32'h6);
    idle(100);
    wr(0, SN, 0);
    rd(0, SN, 900, 900, "snap_live");
    wr(0, PE, 5);
    idle(1);
    wr(0, SN, 0);
    rd(0, SN, 5, 5, "snap_after_reload");
    rd(0, ST, 0, 0, "period_wr_stops");

    // Out-of-range channel 3.
    wr(3, PE, 7);
    wr(3, CT, 32'h7);
    rd(3, PE, 0, 0, "oor_period");
    rd(3, CT, 0, 0, "oor_control");
    rd(3, ST, 0, 0, "oor_status");
    rd(1, PE, 9, 9, "oor_no_alias");

    // Reset mid-count with an interrupt pending.
    wr(1, CT, 32'h7);
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    compare("pre_reset_irq", 32'(seen), 1, 1);
    reset_n = 1'b0;
    chk_irq(0, "reset_irq");
    rd(1, PE, 0, 0, "reset_readdata");
    reset_n = 1'b1;
    rd(1, PE, 19999, 19999, "reset_period");
    rd(1, ST, 0, 0, "reset_status");
    rd(1, CT, 0, 0, "reset_control");
    rd(0, SN, 0, 0, "reset_snap");
    rd(2, PE, 19999, 19999, "reset_period_ch2");
    idle(30);
    chk_irq(0, "reset_quiet");

    idle(3);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
